// File: rtl/dilithium_job_arbiter.sv
// ---------------------------------------------------------------------------
// dilithium_job_arbiter
//   Shares one Dilithium core (plus its stream adapter) between NUM_REQ job
//   masters. Checks each request for a legal mode/security level, grants the
//   requesters round-robin, pulses core_start, and connects the 64-bit input
//   and output streams to the current owner only. The core is released on the
//   final output handshake.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req/req_mode/req_sec_lvl  per-requester job request (level) and job params
//   gnt, err               one-hot ownership; 1-cycle pulse on illegal request
//   s_valid/s_ready/s_data requester -> core input streams
//   m_valid/m_ready        core -> requester output handshake (per requester)
//   m_data, m_last         shared output data / final-beat flag
//   core_start/mode/sec_lvl  registered job launch to the core
//   core_valid_i/ready_i/data_i  input stream toward the core
//   core_valid_o/ready_o/data_o/last  output stream from the core
//   busy, job_cycles       activity flag; START..final-beat length of last job
// ---------------------------------------------------------------------------
module dilithium_job_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_mode,
    input  logic [3*NUM_REQ-1:0]    req_sec_lvl,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      err,
    input  logic [NUM_REQ-1:0]      s_valid,
    output logic [NUM_REQ-1:0]      s_ready,
    input  logic [64*NUM_REQ-1:0]   s_data,
    output logic [NUM_REQ-1:0]      m_valid,
    input  logic [NUM_REQ-1:0]      m_ready,
    output logic [63:0]             m_data,
    output logic                    m_last,
    output logic                    core_start,
    output logic [1:0]              core_mode,
    output logic [2:0]              core_sec_lvl,
    output logic                    core_valid_i,
    input  logic                    core_ready_i,
    output logic [63:0]             core_data_i,
    input  logic                    core_valid_o,
    output logic                    core_ready_o,
    input  logic [63:0]             core_data_o,
    input  logic                    core_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        job_cycles
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   rr_ptr_q, owner_q;
    logic [NUM_REQ-1:0] gnt_q, err_q;
    logic               core_start_q;
    logic [1:0]         core_mode_q;
    logic [2:0]         core_sec_q;
    logic [CNT_W-1:0]   cnt_q, job_cycles_q;

    logic               cand_found;
    logic [PTR_W-1:0]   cand_idx;
    logic [1:0]         cand_mode;
    logic [2:0]         cand_sec;
    logic               cand_legal;
    logic [NUM_REQ-1:0] cand_oh;
    logic               done;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    // First requester at or after rr_ptr (wrapping) wins the selection.
    always_comb begin
        int idx;
        idx        = 0;
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_mode  = '0;
        cand_sec   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!cand_found && req[idx]) begin
                cand_found = 1'b1;
                cand_idx   = PTR_W'(idx);
                cand_mode  = req_mode[2*idx +: 2];
                cand_sec   = req_sec_lvl[3*idx +: 3];
            end
        end
        cand_legal = (cand_mode != 2'd3) &&
                     (cand_sec == 3'd2 || cand_sec == 3'd3 || cand_sec == 3'd5);
        cand_oh    = NUM_REQ'(1) << cand_idx;
    end

    // Stream routing is combinational and only open in BUSY, so START and
    // reset both force every handshake signal low.
    always_comb begin
        core_valid_i = 1'b0;
        core_data_i  = '0;
        core_ready_o = 1'b0;
        s_ready      = '0;
        m_valid      = '0;
        m_data       = '0;
        m_last       = 1'b0;
        if (state_q == BUSY) begin
            core_valid_i     = s_valid[owner_q];
            core_data_i      = s_data[64*int'(owner_q) +: 64];
            s_ready[owner_q] = core_ready_i;
            m_valid[owner_q] = core_valid_o;
            m_data           = core_data_o;
            m_last           = core_last;
            core_ready_o     = m_ready[owner_q];
        end
    end

    assign done = (state_q == BUSY) && core_valid_o && m_ready[owner_q] && core_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            gnt_q        <= '0;
            err_q        <= '0;
            core_start_q <= 1'b0;
            core_mode_q  <= '0;
            core_sec_q   <= '0;
            cnt_q        <= '0;
            job_cycles_q <= '0;
        end else begin
            err_q        <= '0;
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand_found) begin
                        if (cand_legal) begin
                            owner_q      <= cand_idx;
                            core_mode_q  <= cand_mode;
                            core_sec_q   <= cand_sec;
                            gnt_q        <= cand_oh;
                            core_start_q <= 1'b1;
                            state_q      <= START;
                        end else begin
                            // Skip past the offender so others get a turn.
                            err_q    <= cand_oh;
                            rr_ptr_q <= inc_ptr(cand_idx);
                        end
                    end
                end
                START: begin
                    cnt_q   <= CNT_W'(1);
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (done) begin
                        // Count includes the final-beat cycle itself.
                        job_cycles_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        gnt_q        <= '0;
                        rr_ptr_q     <= inc_ptr(owner_q);
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign err          = err_q;
    assign core_start   = core_start_q;
    assign core_mode    = core_mode_q;
    assign core_sec_lvl = core_sec_q;
    assign busy         = (state_q != IDLE);
    assign job_cycles   = job_cycles_q;

endmodule

// File: doc/dilithium_job_arbiter.md
Name: dilithium_job_arbiter

Overview:
- Shares one combined Dilithium core (with its stream adapter) between NUM_REQ independent requesters.
- Each requester raises a job request carrying mode and sec_lvl.
- The arbiter validates the request, grants round-robin and issues the core start pulse. It routes the 64-bit input/output streams to the owner only, and releases the core on the final output beat.
- Sits between the SoC-side job masters and the dilithium top.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- CNT_W, 32, width of the per-job cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  job request per requester; level, held until gnt.
- req_mode  in  2*NUM_REQ  mode per requester; slice i = [2i+1:2i].
- req_sec_lvl  in  3*NUM_REQ  security level per requester; slice i = [3i+2:3i].
- gnt  out  NUM_REQ  one-hot; high for the owner from START through the final output beat.
- err  out  NUM_REQ  1-cycle pulse: illegal request rejected.
- s_valid  in  NUM_REQ  per-requester input stream valid.
- s_ready  out  NUM_REQ  per-requester input stream ready.
- s_data  in  64*NUM_REQ  per-requester input data.
- m_valid  out  NUM_REQ  per-requester output valid.
- m_ready  in  NUM_REQ  per-requester output ready.
- m_data  out  64  shared output data; qualify with m_valid.
- m_last  out  1  final-beat flag; qualify with the owner's m_valid.
- core_start  out  1  start to core; registered 1-cycle pulse.
- core_mode  out  2  registered, stable for the whole job.
- core_sec_lvl  out  3  registered, stable for the whole job.
- core_valid_i  out  1  to core.
- core_ready_i  in  1  from core.
- core_data_i  out  64  to core.
- core_valid_o  in  1  from core.
- core_ready_o  out  1  to core.
- core_data_o  in  64  from core.
- core_last  in  1  from core.
- busy  out  1  high in START and BUSY.
- job_cycles  out  CNT_W  cycles START..final beat of the last completed job.

Behaviour:
- Reset (async, any state), all values 0:
  - gnt, err, s_ready, m_valid, m_last, core_start, core_valid_i, core_ready_o, busy: 0.
  - core_mode, core_sec_lvl, job_cycles, m_data, core_data_i: 0.
  - rr_ptr := 0; state := IDLE.
  - Reset mid-job drops ownership immediately; no completion is recorded.
- States: IDLE, START, BUSY.
- IDLE, selection:
  - Candidate = first i with req[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - If none, stay in IDLE.
- IDLE, illegal candidate (mode==3, or sec_lvl not in {2,3,5}):
  - err[i] pulses for exactly one cycle; no grant.
  - rr_ptr := i+1 mod NUM_REQ; stay in IDLE.
  - A requester that holds an illegal req re-errors every time it is selected; others are not starved.
- IDLE, legal candidate:
  - Register owner := i, core_mode, core_sec_lvl; gnt[i] := 1.
  - core_start := 1 for this one registered cycle; go to START.
- START (1 cycle):
  - core_start=1, busy=1, all streams blocked (core_valid_i=0, core_ready_o=0, s_ready=0, m_valid=0).
  - job counter := 1; go to BUSY.
- BUSY, routing (combinational, owner only):
  - Input path: core_valid_i=s_valid[owner], core_data_i=s_data[owner], s_ready[owner]=core_ready_i.
  - Output path: m_valid[owner]=core_valid_o, m_data=core_data_o, m_last=core_last, core_ready_o=m_ready[owner].
  - Non-owners see s_ready=0 and m_valid=0; their s_valid/m_ready are ignored.
  - Job counter increments every cycle, saturating at all-ones.
- BUSY, completion: on core_valid_o & m_ready[owner] & core_last (final handshake):
  - job_cycles := counter+1; gnt := 0; rr_ptr := owner+1 mod NUM_REQ; go to IDLE.
- Back-to-back jobs: a mandatory IDLE cycle between jobs keeps core_start low at least 2 cycles, so the core's start edge detector re-arms.
- Dropping req: deasserting req after gnt has no effect; the job runs to its final beat.
- Zero-length input (keygen): legal; the owner simply never sees s_ready rise before output.
- Latency: req to gnt/core_start = 1 cycle when the core is idle; core_start is never asserted while busy.

Test Plan:
- Single job: req[0], mode=0, sec=2 -> gnt[0] and core_start high the next cycle, core_start for 1 cycle. Core emits 4 beats, last on beat 4 with m_ready=1 -> gnt falls the following cycle; job_cycles equals measured count.
- Contention, two requesters:
  - req[0] and req[1] together from reset -> req0 served first, then req1 after exactly 1 IDLE cycle.
  - Both re-request immediately -> req1 granted before req0.
- Illegal request: req[1], sec_lvl=4 -> err[1] 1-cycle pulse, no core_start. With req[0] legal and also pending -> req0 granted on the next cycle.
- Isolation: during req0's job, drive s_valid[1]=1 and m_ready[1]=0 -> s_ready[1]=0, m_valid[1]=0, core_data_i always tracks s_data[0]. Stall m_ready[0]=0 on the last beat for 5 cycles -> gnt held; release on handshake.
- Reset mid-job: assert rst during BUSY -> all outputs 0 asynchronously. After release, a new req[1] is granted with rr_ptr=0 ordering.
